// File: rtl/apb_uart_core_if.sv
// APB3 bus bundle for apb_uart_core; the bus requester drives the master modport.
interface apb_uart_core_if #(
    parameter int ApbAddrWidth = 32,
    parameter int ApbDataWidth = 32
);
    logic [ApbAddrWidth-1:0] paddr;
    logic [ApbDataWidth-1:0] pwdata;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [ApbDataWidth-1:0] prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (output paddr, pwdata, pwrite, psel, penable,
                    input  prdata, pready, pslverr);
    modport slave  (input  paddr, pwdata, pwrite, psel, penable,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/apb_uart_core.sv
// APB3-slave 8N1 UART with TX/RX FIFOs, baud divisor and level interrupt; rstn is synchronous, active-high.
// Define APB_UART_LOOPBACK_EN to implement the internal loopback bit (CTRL bit5).
module apb_uart_core #(
    parameter int ApbAddrWidth = 32,
    parameter int ApbDataWidth = 32,
    parameter int FifoDepth    = 4,
    parameter int DefaultDiv   = 86
) (
    input  logic           clk,
    input  logic           rstn,
    apb_uart_core_if.slave apb,
    input  logic           rx_i,
    output logic           tx_o,
    output logic           event_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam logic [PtrW:0] PtrOne = 1;
    localparam logic [2:0] R_TXDATA = 3'd0, R_RXDATA = 3'd1, R_STATUS = 3'd2,
                           R_CTRL = 3'd3, R_DIV = 3'd4;
`ifdef APB_UART_LOOPBACK_EN
    localparam logic [5:0] CtrlMask = 6'h3F;
`else
    localparam logic [5:0] CtrlMask = 6'h1F;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} frame_state_e;

    logic [2:0]  word;
    logic        bad_addr, access, bus_err, wr_en, rd_en;
    logic [5:0]  ctrl;
    logic [15:0] div, eff_div, rx_half;
    logic        overrun, frame_err, overrun_set, frame_err_set, event_q;
    logic [ApbDataWidth-1:0] rdata;
    logic        unused_bus;

    logic [7:0]  tx_mem [FifoDepth];
    logic [7:0]  rx_mem [FifoDepth];
    logic [PtrW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_busy;

    frame_state_e tx_state, tx_state_d, rx_state, rx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d, rx_cnt, rx_cnt_d;
    logic [2:0]  tx_bits, tx_bits_d, rx_bits, rx_bits_d;
    logic [7:0]  tx_shift, tx_shift_d, rx_shift, rx_shift_d;
    logic        tx_q, tx_line_d, rx_src, rx_s1, rx_sync, rx_prev;

    assign word     = apb.paddr[4:2];
    assign bad_addr = (apb.paddr[1:0] != 2'b00) || (word > R_DIV);
    assign access   = apb.psel && apb.penable;
    assign bus_err  = access && (bad_addr || (apb.pwrite && word == R_TXDATA && tx_full));
    assign wr_en    = access && apb.pwrite && !bus_err;
    assign rd_en    = access && !apb.pwrite && !bus_err;
    assign apb.pslverr = bus_err;
    assign apb.pready  = 1'b1;
    assign unused_bus  = ^{apb.paddr[ApbAddrWidth-1:5], apb.pwdata[ApbDataWidth-1:16]};

    assign eff_div = (div < 16'd3) ? 16'd3 : div;
    // The detector already lags the synchronized edge by one clock, hence the extra -1.
    assign rx_half = 16'((17'(eff_div) + 17'd1) >> 1) - 16'd2;

    assign tx_push  = wr_en && word == R_TXDATA;
    assign rx_pop   = rd_en && word == R_RXDATA && !rx_empty;
    assign tx_empty = tx_wp == tx_rp;
    assign rx_empty = rx_wp == rx_rp;
    assign tx_full  = (tx_wp[PtrW] != tx_rp[PtrW]) && (tx_wp[PtrW-1:0] == tx_rp[PtrW-1:0]);
    assign rx_full  = (rx_wp[PtrW] != rx_rp[PtrW]) && (rx_wp[PtrW-1:0] == rx_rp[PtrW-1:0]);
    assign tx_busy  = tx_state != S_IDLE;

`ifdef APB_UART_LOOPBACK_EN
    assign rx_src = ctrl[5] ? tx_q : rx_i;
    assign tx_o   = ctrl[5] ? 1'b1 : tx_q;
`else
    assign rx_src = rx_i;
    assign tx_o   = tx_q;
`endif
    assign event_o = event_q;

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[PtrW-1:0]] <= apb.pwdata[7:0];
        if (rx_push) rx_mem[rx_wp[PtrW-1:0]] <= rx_shift;
    end

    // NOTE: every clocked block uses non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
            ctrl <= '0; div <= 16'(DefaultDiv);
            overrun <= 1'b0; frame_err <= 1'b0; event_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PtrOne;
            if (tx_pop)  tx_rp <= tx_rp + PtrOne;
            if (rx_push) rx_wp <= rx_wp + PtrOne;
            if (rx_pop)  rx_rp <= rx_rp + PtrOne;
            if (wr_en && word == R_CTRL) ctrl <= apb.pwdata[5:0] & CtrlMask;
            if (wr_en && word == R_DIV)  div  <= apb.pwdata[15:0];
            // A new error arriving with its W1C clear keeps the flag set.
            overrun   <= overrun_set || (overrun && !(wr_en && word == R_STATUS && apb.pwdata[5]));
            frame_err <= frame_err_set || (frame_err && !(wr_en && word == R_STATUS && apb.pwdata[6]));
            event_q   <= (ctrl[2] && !rx_empty) || (ctrl[3] && tx_empty && !tx_busy) ||
                         (ctrl[4] && (overrun || frame_err));
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            tx_state <= S_IDLE; tx_cnt <= '0; tx_bits <= '0; tx_shift <= '0; tx_q <= 1'b1;
            rx_state <= S_IDLE; rx_cnt <= '0; rx_bits <= '0; rx_shift <= '0;
            rx_s1 <= 1'b1; rx_sync <= 1'b1; rx_prev <= 1'b1;
        end else begin
            tx_state <= tx_state_d; tx_cnt <= tx_cnt_d; tx_bits <= tx_bits_d;
            tx_shift <= tx_shift_d; tx_q <= tx_line_d;
            rx_state <= rx_state_d; rx_cnt <= rx_cnt_d; rx_bits <= rx_bits_d; rx_shift <= rx_shift_d;
            rx_s1 <= rx_src; rx_sync <= rx_s1; rx_prev <= rx_sync;
        end
    end

    // NOTE: each comb block assigns every output a default first, so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state; tx_cnt_d = tx_cnt; tx_bits_d = tx_bits;
        tx_shift_d = tx_shift; tx_pop = 1'b0;
        case (tx_state)
            S_IDLE: if (ctrl[0] && !tx_empty) begin
                tx_pop = 1'b1; tx_state_d = S_START; tx_cnt_d = eff_div;
                tx_shift_d = tx_mem[tx_rp[PtrW-1:0]];
            end
            S_START: if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
                     else begin tx_state_d = S_DATA; tx_cnt_d = eff_div; tx_bits_d = '0; end
            S_DATA: if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
                    else begin
                        tx_cnt_d = eff_div; tx_shift_d = tx_shift >> 1;
                        if (tx_bits == 3'd7) tx_state_d = S_STOP;
                        else tx_bits_d = tx_bits + 3'd1;
                    end
            S_STOP: if (tx_cnt != 16'd0) tx_cnt_d = tx_cnt - 16'd1;
                    else tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
        tx_line_d = (tx_state_d == S_START) ? 1'b0 :
                    (tx_state_d == S_DATA)  ? tx_shift_d[0] : 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state; rx_cnt_d = rx_cnt; rx_bits_d = rx_bits; rx_shift_d = rx_shift;
        rx_push = 1'b0; overrun_set = 1'b0; frame_err_set = 1'b0;
        case (rx_state)
            S_IDLE: if (ctrl[1] && rx_prev && !rx_sync) begin
                rx_state_d = S_START; rx_cnt_d = rx_half;
            end
            S_START: if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
                     else if (rx_sync) rx_state_d = S_IDLE;
                     else begin rx_state_d = S_DATA; rx_cnt_d = eff_div; rx_bits_d = '0; end
            S_DATA: if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
                    else begin
                        rx_cnt_d = eff_div; rx_shift_d = {rx_sync, rx_shift[7:1]};
                        if (rx_bits == 3'd7) rx_state_d = S_STOP;
                        else rx_bits_d = rx_bits + 3'd1;
                    end
            S_STOP: if (rx_cnt != 16'd0) rx_cnt_d = rx_cnt - 16'd1;
                    else begin
                        rx_state_d = S_IDLE;
                        if (!rx_sync) frame_err_set = 1'b1;
                        else if (rx_full && !rx_pop) overrun_set = 1'b1;
                        else rx_push = 1'b1;
                    end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (word)
            R_RXDATA: if (!rx_empty) rdata[7:0] = rx_mem[rx_rp[PtrW-1:0]];
            R_STATUS: rdata[6:0] = {frame_err, overrun, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
            R_CTRL:   rdata[5:0] = ctrl;
            R_DIV:    rdata[15:0] = div;
            default:  rdata = '0;
        endcase
        if (bad_addr || !apb.psel || apb.pwrite) rdata = '0;
    end
    assign apb.prdata = rdata;
endmodule

// File: tb/tb_apb_uart_core.sv
// Self-checking bench for apb_uart_core: register table, hand-built serial sequences and
// randomized loopback traffic compared with a queue-based byte model.
module tb_apb_uart_core;
    localparam logic [31:0] A_TX = 32'h00, A_RX = 32'h04, A_ST = 32'h08, A_CTRL = 32'h0C, A_DIV = 32'h10;
`ifdef APB_UART_LOOPBACK_EN
    localparam logic [31:0] CtrlAll = 32'h3F;
`else
    localparam logic [31:0] CtrlAll = 32'h1F;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic loop_sel = 1'b0;
    logic rx_drv = 1'b1;
    logic rx_line, tx_o, event_o;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    apb_uart_core_if #(.ApbAddrWidth(32), .ApbDataWidth(32)) bus ();
    assign rx_line = loop_sel ? tx_o : rx_drv;

    apb_uart_core #(.ApbAddrWidth(32), .ApbDataWidth(32), .FifoDepth(4), .DefaultDiv(86)) dut (
        .clk(clk), .rstn(rstn), .apb(bus), .rx_i(rx_line), .tx_o(tx_o), .event_o(event_o)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs[$];
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge clk);
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b1, addr, data, r, e);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        apb_xfer(1'b0, addr, 32'h0, r, e);
        check(name, r, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop_bit, input int bit_clks);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = frame[i];
            repeat (bit_clks - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        bit          found;
        int          cyc, low, div, eff, n, tz;
        logic [7:0]  b;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", tx_o, 1);
        check("rst_event", event_o, 0);
        check("pready", bus.pready, 1);
        rstn = 1'b0;

        // Register-map table straight out of reset.
        vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0A, 1'b0, "status_rst"});
        vecs.push_back('{1'b0, 32'h0C, 32'h0, 32'h00, 1'b0, "ctrl_rst"});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 32'd86, 1'b0, "div_rst"});
        vecs.push_back('{1'b0, 32'h00, 32'h0, 32'h00, 1'b0, "txdata_rd"});
        vecs.push_back('{1'b0, 32'h04, 32'h0, 32'h00, 1'b0, "rxdata_empty"});
        vecs.push_back('{1'b1, 32'h10, 32'hFFFF0005, 32'h0, 1'b0, "div_wr"});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h05, 1'b0, "div_rd"});
        vecs.push_back('{1'b1, 32'h0C, 32'hFF, 32'h0, 1'b0, "ctrl_wr"});
        vecs.push_back('{1'b0, 32'h0C, 32'h0, CtrlAll, 1'b0, "ctrl_rd"});
        vecs.push_back('{1'b1, 32'h0C, 32'h00, 32'h0, 1'b0, "ctrl_clr"});
        vecs.push_back('{1'b0, 32'h14, 32'h0, 32'h00, 1'b1, "rd_0x14"});
        vecs.push_back('{1'b1, 32'h02, 32'hAB, 32'h0, 1'b1, "wr_0x02"});
        vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0A, 1'b0, "status_after_bad"});
        vecs.push_back('{1'b1, 32'h12, 32'h09, 32'h0, 1'b1, "wr_0x12"});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 32'h05, 1'b0, "div_unchanged"});
        vecs.push_back('{1'b0, 32'h1C, 32'h0, 32'h00, 1'b1, "rd_0x1c"});
        vecs.push_back('{1'b1, 32'h04, 32'h77, 32'h0, 1'b0, "rxdata_wr_ignored"});
        vecs.push_back('{1'b0, 32'h08, 32'h0, 32'h0A, 1'b0, "status_final"});
        for (int i = 0; i < vecs.size(); i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e);
            check({vecs[i].name, "_err"}, e, vecs[i].exp_err);
            if (!vecs[i].wr) check({vecs[i].name, "_data"}, r, vecs[i].exp_rd);
        end

        // Reset mid-frame: line must return high one clock later.
        do_reset();
        reg_wr(A_DIV, 3);
        reg_wr(A_CTRL, 32'h01);
        reg_wr(A_TX, 32'h00);
        repeat (8) @(posedge clk);
        #1;
        check("midframe_low", tx_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_rst_tx_o", tx_o, 1);
        @(negedge clk);
        rstn = 1'b0;
        rd_check("midframe_status", A_ST, 32'h0A);
        rd_check("midframe_ctrl", A_CTRL, 32'h00);

        // Single byte loopback with receive interrupt.
        do_reset();
        loop_sel = 1'b1;
        reg_wr(A_DIV, 3);
        reg_wr(A_CTRL, 32'h07);
        reg_wr(A_TX, 32'h55);
        found = 1'b0;
        for (int i = 1; i <= 42 && !found; i++) begin
            @(posedge clk);
            #1;
            if (event_o) found = 1'b1;
        end
        check("lb_event_within_42", found, 1);
        rd_check("lb_rxdata", A_RX, 32'h55);
        rd_check("lb_status", A_ST, 32'h0A);
        repeat (2) @(posedge clk);
        #1;
        check("lb_event_drop", event_o, 0);

        // TX FIFO full with transmitter disabled.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b1, A_TX, 32'h10 + i, r, e);
            check($sformatf("txfull_wr%0d_err", i), e, (i == 4) ? 1 : 0);
        end
        rd_check("txfull_status", A_ST, 32'h09);

        // Overrun: five bytes looped back, nobody reads.
        do_reset();
        loop_sel = 1'b1;
        reg_wr(A_DIV, 3);
        reg_wr(A_CTRL, 32'h03);
        for (int i = 1; i <= 5; i++) reg_wr(A_TX, i);
        repeat (260) @(posedge clk);
        rd_check("ovr_status", A_ST, 32'h26);
        for (int i = 1; i <= 4; i++) rd_check($sformatf("ovr_rx%0d", i), A_RX, i);
        rd_check("ovr_status_drained", A_ST, 32'h2A);
        reg_wr(A_ST, 32'h20);
        rd_check("ovr_cleared", A_ST, 32'h0A);

        // Externally driven frames: one good, one with stop bit low.
        do_reset();
        loop_sel = 1'b0;
        rx_drv = 1'b1;
        reg_wr(A_DIV, 3);
        reg_wr(A_CTRL, 32'h12);
        send_serial(8'h3C, 1'b1, 4);
        repeat (6) @(negedge clk);
        rd_check("ext_good_rx", A_RX, 32'h3C);
        send_serial(8'hA3, 1'b0, 4);
        repeat (10) @(negedge clk);
        rd_check("ferr_status", A_ST, 32'h4A);
        check("ferr_event", event_o, 1);
        reg_wr(A_ST, 32'h40);
        rd_check("ferr_cleared", A_ST, 32'h0A);
        repeat (2) @(posedge clk);
        #1;
        check("ferr_event_drop", event_o, 0);

        // Randomized loopback traffic against the byte-queue model.
        do_reset();
        loop_sel = 1'b1;
        for (int it = 0; it < 8; it++) begin
            div = $urandom_range(0, 6);
            eff = (div < 3) ? 3 : div;
            n   = $urandom_range(1, 4);
            reg_wr(A_DIV, div);
            reg_wr(A_CTRL, 32'h03);
            b = 8'($urandom_range(0, 255));
            model_q.push_back(b);
            reg_wr(A_TX, {24'h0, b});
            cyc = 0;
            while (tx_o === 1'b1 && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check($sformatf("rnd%0d_tx_fall_within_2", it), 32'(cyc <= 2), 1);
            low = 0;
            while (tx_o === 1'b0 && low < 200) begin
                @(posedge clk);
                #1;
                low++;
            end
            tz = 0;
            while (tz < 8 && b[tz] == 1'b0) tz++;
            check($sformatf("rnd%0d_low_run_b%0h_d%0d", it, b, div), low, (eff + 1) * (1 + tz));
            for (int k = 1; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                model_q.push_back(b);
                reg_wr(A_TX, {24'h0, b});
            end
            repeat (n * 10 * (eff + 1) + 10 * n + 30) @(posedge clk);
            while (model_q.size() > 0) begin
                b = model_q.pop_front();
                rd_check($sformatf("rnd%0d_rx", it), A_RX, {24'h0, b});
            end
            rd_check($sformatf("rnd%0d_status", it), A_ST, 32'h0A);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
